my_exor: RTL and testbench

- Bitwise 2-input XOR primitive with a registered shadow path and simple difference statistics, used as a basic-gate building block.
- Primary output `out` is purely combinational, so `in1 ^ in2` is valid within the same time step, independent of clock and reset.
- Registered side outputs provide the pipelined XOR result, its parity and Hamming weight, and a saturating count of cycles where the inputs differ.
- One clock domain.

---
 rtl/my_exor.sv | 64 ++++++
 tb/tb_my_exor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/my_exor.sv
// Bitwise XOR gate with a registered shadow of the result, its parity and
// popcount, and a saturating count of cycles in which the operands differ.

module my_exor_bit (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module my_exor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    localparam int WW   = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             parity_q,
    output logic [WW-1:0]    weight_q,
    output logic [CNT_W-1:0] diff_cnt,
    output logic             diff_sat
);

    // Combinational path stays clock/reset independent.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        my_exor_bit u_bit (
            .a(in1[i]),
            .b(in2[i]),
            .y(out[i])
        );
    end

    logic [WW-1:0] weight_nxt;

    always_comb begin
        weight_nxt = '0;
        for (int i = 0; i < WIDTH; i++)
            weight_nxt = weight_nxt + WW'(out[i]);
    end

    assign diff_sat = &diff_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= '0;
            parity_q <= 1'b0;
            weight_q <= '0;
            diff_cnt <= '0;
        end else begin
            out_q    <= out;
            parity_q <= ^out;
            weight_q <= weight_nxt;
            // Counter holds at all-ones rather than wrapping.
            if ((|out) && !diff_sat)
                diff_cnt <= diff_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_my_exor.sv
// Self-checking bench for my_exor: a 1-bit default instance for the gate
// truth table and a 4-bit, 3-bit-counter instance for the registered path.

module tb_my_exor;

    logic       clk = 1'b0;
    logic       rst1, rst4;
    logic [0:0] a1, b1;
    logic [0:0] y1, yq1, w1;
    logic       p1, s1;
    logic [15:0] c1;
    logic [3:0] a4, b4, y4, yq4;
    logic       p4, s4;
    logic [2:0] w4, c4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] oq;
        logic       par;
        logic [2:0] w;
        logic [2:0] cnt;
        logic       sat;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m_cnt;

    always #5 clk = ~clk;

    my_exor u_w1 (
        .clk(clk), .rst(rst1), .in1(a1), .in2(b1), .out(y1), .out_q(yq1),
        .parity_q(p1), .weight_q(w1), .diff_cnt(c1), .diff_sat(s1)
    );

    my_exor #(.WIDTH(4), .CNT_W(3)) u_w4 (
        .clk(clk), .rst(rst4), .in1(a4), .in2(b4), .out(y4), .out_q(yq4),
        .parity_q(p4), .weight_q(w4), .diff_cnt(c4), .diff_sat(s4)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    // Push the expected post-edge state, clock once, pop and compare.
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        exp_t e, g;
        logic [3:0] d;
        a4 = a; b4 = b;
        d = a ^ b;
        if (d != 4'd0 && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
        e.oq = d; e.par = ^d; e.w = 3'($countones(d));
        e.cnt = m_cnt; e.sat = (m_cnt == 3'd7);
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        n_tests++;
        if (y4 !== d) begin n_fail++; $display("FAIL out: got %b want %b", y4, d); end
        n_tests++;
        if (yq4 !== g.oq) begin n_fail++; $display("FAIL out_q: got %b want %b", yq4, g.oq); end
        n_tests++;
        if (p4 !== g.par) begin n_fail++; $display("FAIL parity_q: got %b want %b", p4, g.par); end
        n_tests++;
        if (w4 !== g.w) begin n_fail++; $display("FAIL weight_q: got %0d want %0d", w4, g.w); end
        n_tests++;
        if (c4 !== g.cnt) begin n_fail++; $display("FAIL diff_cnt: got %0d want %0d", c4, g.cnt); end
        n_tests++;
        if (s4 !== g.sat) begin n_fail++; $display("FAIL diff_sat: got %b want %b", s4, g.sat); end
    endtask

    task automatic check_w4_cleared(input string tag);
        n_tests++;
        if ({yq4, p4, w4, c4, s4} !== 12'd0) begin
            n_fail++;
            $display("FAIL %s: registered got oq=%b p=%b w=%0d c=%0d s=%b want all 0",
                     tag, yq4, p4, w4, c4, s4);
        end
    endtask

    task automatic reset_w4();
        @(negedge clk);
        rst4 = 1'b1; #1;
        m_cnt = 3'd0;
        check_w4_cleared("reset_w4");
        @(negedge clk);
        rst4 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        m_cnt = 3'd0;
        #1;
        check_w4_cleared("reset_state_w4");
        n_tests++;
        if ({yq1, p1, w1, c1, s1} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state_w1: got oq=%b p=%b w=%0d c=%0d s=%b want all 0",
                     yq1, p1, w1, c1, s1);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] v;
        logic exp_y [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            a1 = v[1]; b1 = v[0];
            #10;
            n_tests++;
            if (y1 !== exp_y[i]) begin
                n_fail++;
                $display("FAIL truth_%b: out got %b want %b", v, y1, exp_y[i]);
            end
            n_tests++;
            if ({yq1, p1, w1, c1} !== 19'd0) begin
                n_fail++;
                $display("FAIL truth_reg_%b: got oq=%b c=%0d want 0", v, yq1, c1);
            end
        end
    endtask

    task automatic test_w1_path();
        @(negedge clk);
        rst1 = 1'b0;
        a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({yq1, p1, w1, c1, s1} !== {1'b1, 1'b1, 1'b1, 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL w1_diff: got oq=%b p=%b w=%0d c=%0d s=%b want 1 1 1 1 0",
                     yq1, p1, w1, c1, s1);
        end
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({yq1, p1, w1, c1} !== {1'b0, 1'b0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL w1_equal: got oq=%b p=%b w=%0d c=%0d want 0 0 0 1",
                     yq1, p1, w1, c1);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst4 = 1'b0;
        step(4'b1010, 4'b0110);
        n_tests++;
        if ({yq4, p4, w4, c4} !== {4'b1100, 1'b0, 3'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL registered_1010_0110: got oq=%b p=%b w=%0d c=%0d want 1100 0 2 1",
                     yq4, p4, w4, c4);
        end
        step(4'b0000, 4'b0111);
        step(4'b1111, 4'b0000);
    endtask

    task automatic test_equal();
        for (int i = 0; i < 5; i++) step(4'hF, 4'hF);
    endtask

    task automatic test_saturation();
        reset_w4();
        for (int i = 1; i <= 10; i++) begin
            step(4'b0001, 4'b0000);
            n_tests++;
            if (s4 !== (i >= 7)) begin
                n_fail++;
                $display("FAIL sat_edge_%0d: diff_sat got %b want %b", i, s4, (i >= 7));
            end
        end
    endtask

    task automatic test_async_reset();
        reset_w4();
        for (int i = 0; i < 5; i++) step(4'b0011, 4'b0101);
        n_tests++;
        if (c4 !== 3'd5) begin
            n_fail++;
            $display("FAIL precount: diff_cnt got %0d want 5", c4);
        end
        #2 rst4 = 1'b1;
        #1;
        check_w4_cleared("async_clear");
        n_tests++;
        if (y4 !== 4'b0110) begin
            n_fail++;
            $display("FAIL async_out: out got %b want 0110", y4);
        end
        #1 rst4 = 1'b0;
        m_cnt = 3'd0;
        step(4'b1000, 4'b0001);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_w1_path();
        test_registered();
        test_equal();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
